mfsk_mod: RTL and testbench

MFSK_MOD -- requirements
Module: mfsk_mod

---
 rtl/mfsk_mod.sv | 156 +++++++++++++++
 tb/tb_mfsk_mod.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfsk_mod.sv
// rtl/mfsk_mod.sv - M-ary FSK modulator: symbol FIFO, per-tone tuning table, continuous-phase accumulator.
// Each symbol holds its tuning word for SPS samples; the accumulator never resets except on rst.
module mfsk_mod #(
  parameter int BITS    = 2,
  parameter int PHASE_W = 32,
  parameter int SPS_W   = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [BITS:0]      cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic               sym_valid,
  input  logic [BITS-1:0]    sym_data,
  output logic               sym_ready,
  output logic [PHASE_W-1:0] phase,
  output logic               out_valid,
  output logic [BITS-1:0]    tone,
  output logic               sym_strobe,
  output logic               underrun,
  output logic               busy
);

  localparam int M  = 1 << BITS;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  logic [PHASE_W-1:0] tw_q [M];
  logic [PHASE_W-1:0] tw_d [M];
  logic [SPS_W-1:0]   sps_q, sps_d;
  logic [BITS-1:0]    fifo_q [DEPTH];
  logic [BITS-1:0]    fifo_d [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  state_t             state_q, state_d;
  logic [SPS_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [BITS-1:0]    tone_q, tone_d;
  logic               out_valid_q, out_valid_d;
  logic               sym_strobe_q, sym_strobe_d;
  logic               underrun_q, underrun_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [BITS-1:0]    head;
  logic [PHASE_W-1:0] head_tw;
  logic [SPS_W-1:0]   start_cnt;
  logic [AW:0]        ptr_one;

  assign ptr_one    = {{AW{1'b0}}, 1'b1};
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = sym_valid && !fifo_full;
  assign pop        = !fifo_empty && ((state_q == IDLE) || (cnt_q == '0));
  assign head       = fifo_q[rd_ptr_q[AW-1:0]];
  assign head_tw    = tw_q[head];
  // A programmed SPS of zero is treated as one sample per symbol.
  assign start_cnt  = (sps_q == '0) ? '0 : (sps_q - SPS_W'(1));

  always_comb begin
    for (int i = 0; i < M; i++) tw_d[i] = tw_q[i];
    for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
    sps_d        = sps_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    phase_d      = phase_q;
    tone_d       = tone_q;
    out_valid_d  = 1'b0;
    sym_strobe_d = 1'b0;
    underrun_d   = 1'b0;

    if (cfg_we) begin
      if (!cfg_addr[BITS]) begin
        tw_d[cfg_addr[BITS-1:0]] = cfg_data;
      end else if (cfg_addr[BITS-1:0] == '0) begin
        sps_d = cfg_data[SPS_W-1:0];
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = sym_data;
      wr_ptr_d = wr_ptr_q + ptr_one;
    end

    // Symbol start reads the pre-edge table, so a same-edge config write waits a symbol.
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + ptr_one;
      state_d      = RUN;
      tone_d       = head;
      step_d       = head_tw;
      cnt_d        = start_cnt;
      phase_d      = phase_q + head_tw;
      out_valid_d  = 1'b1;
      sym_strobe_d = 1'b1;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        phase_d     = phase_q + step_q;
        cnt_d       = cnt_q - SPS_W'(1);
        out_valid_d = 1'b1;
      end else begin
        state_d    = IDLE;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) tw_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      sps_q        <= SPS_W'(1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      step_q       <= '0;
      phase_q      <= '0;
      tone_q       <= '0;
      out_valid_q  <= 1'b0;
      sym_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      for (int i = 0; i < M; i++) tw_q[i] <= tw_d[i];
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
      sps_q        <= sps_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      phase_q      <= phase_d;
      tone_q       <= tone_d;
      out_valid_q  <= out_valid_d;
      sym_strobe_q <= sym_strobe_d;
      underrun_q   <= underrun_d;
    end
  end

  assign sym_ready  = !fifo_full;
  assign phase      = phase_q;
  assign out_valid  = out_valid_q;
  assign tone       = tone_q;
  assign sym_strobe = sym_strobe_q;
  assign underrun   = underrun_q;
  assign busy       = (state_q == RUN) || !fifo_empty;

endmodule

// File: tb/tb_mfsk_mod.sv
// tb/tb_mfsk_mod.sv - self-checking bench for mfsk_mod: vector table, directed corners, random bursts vs model.
module tb_mfsk_mod;
  localparam int BITS = 2;
  localparam int PW   = 32;
  localparam int SW   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_we = 1'b0;
  logic [BITS:0]   cfg_addr = '0;
  logic [PW-1:0]   cfg_data = '0;
  logic            sym_valid = 1'b0;
  logic [BITS-1:0] sym_data = '0;
  logic            sym_ready;
  logic [PW-1:0]   phase;
  logic            out_valid;
  logic [BITS-1:0] tone;
  logic            sym_strobe;
  logic            underrun;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int urun_cnt = 0;
  int last_push_cyc = 0;

  typedef struct {
    logic [PW-1:0]   p;
    logic [BITS-1:0] t;
    logic            s;
    int              c;
  } samp_t;

  typedef struct {
    int              tn;
    logic [PW-1:0]   tw;
    logic [SW-1:0]   sps;
    int              n;
    logic [PW-1:0]   last;
  } vec_t;

  samp_t got[$];
  samp_t exp_q[$];
  samp_t mon_s;
  vec_t  vecs[5];

  mfsk_mod #(.BITS(BITS), .PHASE_W(PW), .SPS_W(SW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .phase(phase), .out_valid(out_valid), .tone(tone), .sym_strobe(sym_strobe),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      mon_s.p = phase;
      mon_s.t = tone;
      mon_s.s = sym_strobe;
      mon_s.c = cyc;
      got.push_back(mon_s);
    end
    if (!rst && underrun) urun_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete();
    urun_cnt = 0;
  endtask

  task automatic cfg_write(input logic [BITS:0] a, input logic [PW-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push(input logic [BITS-1:0] s);
    int n = 0;
    sym_valid = 1'b1;
    sym_data = s;
    while (!sym_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check("push_timeout", 1, 0);
    tick();
    last_push_cyc = cyc;
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(n >= budget), 0);
    tick();
  endtask

  initial begin
    logic [PW-1:0] tw_m [4];
    logic [PW-1:0] acc;
    logic [PW-1:0] e35 [8];
    int sps_m, nsym, pc, ready_rise;
    logic [BITS-1:0] syms [$];
    samp_t es;

    vecs[0] = '{0, 32'hC0000000, 16'd3, 3, 32'h40000000};
    vecs[1] = '{2, 32'h00000010, 16'd0, 1, 32'h00000010};
    vecs[2] = '{3, 32'h00000001, 16'd5, 5, 32'h00000005};
    vecs[3] = '{1, 32'h80000000, 16'd2, 2, 32'h00000000};
    vecs[4] = '{1, 32'hFFFFFFFF, 16'd4, 4, 32'hFFFFFFFC};
    e35 = '{32'h02000000, 32'h04000000, 32'h06000000, 32'h08000000,
            32'h10000000, 32'h18000000, 32'h20000000, 32'h28000000};

    // reset state
    #1 rst = 1'b1;
    #1;
    check("rst_phase", phase, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sym_ready", sym_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tone", tone, 0);
    check("rst_strobe_urun", {sym_strobe, underrun}, 0);
    tick();
    rst = 1'b0;

    // two back-to-back symbols
    do_reset();
    cfg_write(3'd0, 32'h01000000);
    cfg_write(3'd1, 32'h02000000);
    cfg_write(3'd2, 32'h04000000);
    cfg_write(3'd3, 32'h08000000);
    cfg_write(3'd4, 32'd4);
    push(2'd1);
    pc = last_push_cyc;
    push(2'd3);
    wait_idle(50);
    check("b2b_count", got.size(), 8);
    check("b2b_underruns", urun_cnt, 1);
    if (got.size() == 8) begin
      check("b2b_latency", got[0].c, pc + 1);
      check("b2b_contiguous", got[7].c - got[0].c, 7);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b_phase[%0d]", i), got[i].p, e35[i]);
        check($sformatf("b2b_tone[%0d]", i), got[i].t, (i < 4) ? 1 : 3);
        check($sformatf("b2b_strobe[%0d]", i), got[i].s, (i == 0 || i == 4) ? 1 : 0);
      end
    end

    // single-symbol vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg_write(3'(vecs[v].tn), vecs[v].tw);
      cfg_write(3'd4, 32'(vecs[v].sps));
      push(2'(vecs[v].tn));
      pc = last_push_cyc;
      wait_idle(50);
      check($sformatf("vec%0d_count", v), got.size(), vecs[v].n);
      check($sformatf("vec%0d_underrun", v), urun_cnt, 1);
      if (got.size() == vecs[v].n) begin
        check($sformatf("vec%0d_last_phase", v), got[vecs[v].n-1].p, vecs[v].last);
        check($sformatf("vec%0d_tone", v), got[0].t, vecs[v].tn);
        check($sformatf("vec%0d_strobe", v), got[0].s, 1);
        check($sformatf("vec%0d_first_cyc", v), got[0].c, pc + 1);
        check($sformatf("vec%0d_last_cyc", v), got[vecs[v].n-1].c, pc + vecs[v].n);
      end
    end

    // FIFO full and sym_ready recovery
    do_reset();
    cfg_write(3'd4, 32'd100);
    nsym = 0;
    sym_valid = 1'b1;
    sym_data = 2'd0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("full_ready_6th", sym_ready, 0);
      if (sym_ready) nsym++;
      tick();
    end
    sym_valid = 1'b0;
    check("full_accepted", nsym, 5);
    ready_rise = -1;
    for (int i = 0; i < 300 && ready_rise < 0; i++) begin
      if (sym_ready) ready_rise = cyc;
      else tick();
    end
    wait_idle(1000);
    check("full_total", got.size(), 500);
    if (got.size() == 500) begin
      check("full_strobe2", got[100].s, 1);
      check("full_ready_rise", ready_rise, got[100].c);
    end

    // config write mid-symbol
    do_reset();
    cfg_write(3'd1, 32'h00001000);
    cfg_write(3'd4, 32'd4);
    push(2'd1);
    tick();
    cfg_write(3'd1, 32'h00100000);
    push(2'd1);
    wait_idle(50);
    check("cfgmid_count", got.size(), 8);
    if (got.size() == 8) begin
      check("cfgmid_old_last", got[3].p, 32'h00004000);
      check("cfgmid_new_first", got[4].p, 32'h00104000);
      check("cfgmid_new_last", got[7].p, 32'h00404000);
    end

    // asynchronous reset mid-symbol
    do_reset();
    cfg_write(3'd0, 32'h00000100);
    cfg_write(3'd4, 32'd10);
    push(2'd0);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_phase", phase, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_sym_ready", sym_ready, 1);
    check("arst_busy", busy, 0);
    tick();
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < 6; i++) tick();
    check("arst_no_samples", got.size(), 0);

    // random bursts against a sample-stream model
    do_reset();
    acc = '0;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) begin
        tw_m[k] = $urandom();
        cfg_write(3'(k), tw_m[k]);
      end
      sps_m = $urandom_range(0, 5);
      cfg_write(3'd4, 32'(sps_m));
      nsym = $urandom_range(1, 8);
      syms.delete();
      exp_q.delete();
      for (int j = 0; j < nsym; j++) syms.push_back(2'($urandom_range(0, 3)));
      foreach (syms[j]) begin
        for (int k = 0; k < ((sps_m == 0) ? 1 : sps_m); k++) begin
          acc = acc + tw_m[syms[j]];
          es.p = acc;
          es.t = syms[j];
          es.s = (k == 0);
          es.c = 0;
          exp_q.push_back(es);
        end
      end
      got.delete();
      urun_cnt = 0;
      foreach (syms[j]) push(syms[j]);
      wait_idle(200);
      check($sformatf("rnd%0d_count", b), got.size(), exp_q.size());
      check($sformatf("rnd%0d_underrun", b), urun_cnt, 1);
      if (got.size() == exp_q.size()) begin
        check($sformatf("rnd%0d_contig", b), got[got.size()-1].c - got[0].c, got.size() - 1);
        foreach (exp_q[j]) begin
          check($sformatf("rnd%0d_phase[%0d]", b, j), got[j].p, exp_q[j].p);
          check($sformatf("rnd%0d_tone[%0d]", b, j), got[j].t, exp_q[j].t);
          check($sformatf("rnd%0d_strobe[%0d]", b, j), got[j].s, exp_q[j].s);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
